// File: rtl/w0rm_alu_pkg.sv
// Shared definitions for the W0RM ALU sub-units and their issue sequencer.
package w0rm_alu_pkg;

    localparam int SEL_WIDTH  = 2;
    localparam int FLAG_WIDTH = 4;

    localparam logic [SEL_WIDTH-1:0] ALU_UNIT_LOGIC = 2'd0;
    localparam logic [SEL_WIDTH-1:0] ALU_UNIT_SHIFT = 2'd1;
    localparam logic [SEL_WIDTH-1:0] ALU_UNIT_ARITH = 2'd2;
    localparam logic [SEL_WIDTH-1:0] ALU_UNIT_MUL   = 2'd3;

    localparam logic [3:0] ALU_OP_AND = 4'd0;
    localparam logic [3:0] ALU_OP_OR  = 4'd1;
    localparam logic [3:0] ALU_OP_XOR = 4'd2;
    localparam logic [3:0] ALU_OP_NOT = 4'd3;
    localparam logic [3:0] ALU_OP_NEG = 4'd4;
    localparam logic [3:0] ALU_OP_ADD = 4'd5;
    localparam logic [3:0] ALU_OP_SUB = 4'd6;
    localparam logic [3:0] ALU_OP_SHL = 4'd7;
    localparam logic [3:0] ALU_OP_SHR = 4'd8;
    localparam logic [3:0] ALU_OP_MUL = 4'd9;

    localparam int FLAG_ZERO     = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_CARRY    = 2;
    localparam int FLAG_OVERFLOW = 3;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_WAIT  = 2'd2,
        SEQ_DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/w0rm_alu_result_mux.sv
// Picks one sub-unit's result, flags and completion strobe out of the concatenated buses.
module w0rm_alu_result_mux
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_UNITS  = 4
) (
    input  logic [SEL_WIDTH-1:0]             sel,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_result,
    input  logic [NUM_UNITS-1:0]             unit_result_valid,
    input  logic [NUM_UNITS*FLAG_WIDTH-1:0]  unit_flags,
    output logic [DATA_WIDTH-1:0]            result,
    output logic [FLAG_WIDTH-1:0]            flags,
    output logic                             valid
);

    always_comb begin
        result = '0;
        flags  = '0;
        valid  = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (sel == SEL_WIDTH'(k)) begin
                result = unit_result[k*DATA_WIDTH +: DATA_WIDTH];
                flags  = unit_flags[k*FLAG_WIDTH +: FLAG_WIDTH];
                valid  = unit_result_valid[k];
            end
        end
    end

endmodule

// File: rtl/w0rm_alu_sequencer.sv
// Issue controller for the W0RM ALU sub-units: one operation in flight, issue strobe,
// bounded wait for completion, and a held writeback until the consumer takes it.
module w0rm_alu_sequencer
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int NUM_UNITS      = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DEST_WIDTH     = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [SEL_WIDTH-1:0]             in_unit,
    input  logic [3:0]                       in_opcode,
    input  logic [DATA_WIDTH-1:0]            in_a,
    input  logic [DATA_WIDTH-1:0]            in_b,
    input  logic [DEST_WIDTH-1:0]            in_dest,
    output logic [NUM_UNITS-1:0]             unit_data_valid,
    output logic [3:0]                       unit_opcode,
    output logic [DATA_WIDTH-1:0]            unit_a,
    output logic [DATA_WIDTH-1:0]            unit_b,
    input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_result,
    input  logic [NUM_UNITS-1:0]             unit_result_valid,
    input  logic [NUM_UNITS*FLAG_WIDTH-1:0]  unit_flags,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH-1:0]            out_result,
    output logic [FLAG_WIDTH-1:0]            out_flags,
    output logic [DEST_WIDTH-1:0]            out_dest,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam logic [7:0]           WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_UNITS-1:0] UNIT_ONE  = NUM_UNITS'(1);

    seq_state_t                 state;
    logic [SEL_WIDTH-1:0]       sel_q;
    logic [3:0]                 opcode_q;
    logic [DATA_WIDTH-1:0]      a_q;
    logic [DATA_WIDTH-1:0]      b_q;
    logic [DEST_WIDTH-1:0]      dest_q;
    logic [7:0]                 wait_cnt;

    logic [DATA_WIDTH-1:0]      sel_result;
    logic [FLAG_WIDTH-1:0]      sel_flags;
    logic                       sel_valid;

    w0rm_alu_result_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_UNITS  (NUM_UNITS)
    ) u_result_mux (
        .sel               (sel_q),
        .unit_result       (unit_result),
        .unit_result_valid (unit_result_valid),
        .unit_flags        (unit_flags),
        .result            (sel_result),
        .flags             (sel_flags),
        .valid             (sel_valid)
    );

    assign in_ready    = (state == SEQ_IDLE);
    assign busy        = (state != SEQ_IDLE);
    assign unit_opcode = opcode_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= SEQ_IDLE;
            sel_q           <= '0;
            opcode_q        <= '0;
            a_q             <= '0;
            b_q             <= '0;
            dest_q          <= '0;
            wait_cnt        <= '0;
            unit_data_valid <= '0;
            out_valid       <= 1'b0;
            out_result      <= '0;
            out_flags       <= '0;
            out_dest        <= '0;
            timeout_err     <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (in_valid) begin
                        sel_q           <= in_unit;
                        opcode_q        <= in_opcode;
                        a_q             <= in_a;
                        b_q             <= in_b;
                        dest_q          <= in_dest;
                        unit_data_valid <= UNIT_ONE << in_unit;
                        state           <= SEQ_ISSUE;
                    end
                end
                // A single-cycle unit answers while the issue strobe is still up.
                SEQ_ISSUE: begin
                    unit_data_valid <= '0;
                    if (sel_valid) begin
                        out_result <= sel_result;
                        out_flags  <= sel_flags;
                        out_dest   <= dest_q;
                        out_valid  <= 1'b1;
                        state      <= SEQ_DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= SEQ_WAIT;
                    end
                end
                // Completion is tested first so it beats a coincident timeout.
                SEQ_WAIT: begin
                    wait_cnt <= wait_cnt + 8'd1;
                    if (sel_valid) begin
                        out_result <= sel_result;
                        out_flags  <= sel_flags;
                        out_dest   <= dest_q;
                        out_valid  <= 1'b1;
                        state      <= SEQ_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_result  <= '0;
                        out_flags   <= '0;
                        out_dest    <= dest_q;
                        out_valid   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= SEQ_DONE;
                    end
                end
                SEQ_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= SEQ_IDLE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w0rm_alu_sequencer.sv
// Directed bench for w0rm_alu_sequencer: a transaction-level timing model checked every cycle,
// plus literal expectations for each scenario.
module tb_w0rm_alu_sequencer;
    import w0rm_alu_pkg::*;

    localparam int DW = 8;
    localparam int NU = 4;
    localparam int TO = 16;
    localparam int DSTW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      in_unit = '0;
    logic [3:0]      in_opcode = '0;
    logic [DW-1:0]   in_a = '0;
    logic [DW-1:0]   in_b = '0;
    logic [DSTW-1:0] in_dest = '0;
    logic [NU-1:0]   unit_data_valid;
    logic [3:0]      unit_opcode;
    logic [DW-1:0]   unit_a;
    logic [DW-1:0]   unit_b;
    logic [NU*DW-1:0] unit_result;
    logic [NU-1:0]   unit_result_valid;
    logic [NU*4-1:0] unit_flags;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_result;
    logic [3:0]      out_flags;
    logic [DSTW-1:0] out_dest;
    logic            busy;
    logic            timeout_err;

    logic [DW-1:0] u_res [NU];
    logic [3:0]    u_flg [NU];
    logic [NU-1:0] rv = '0;
    logic [NU-1:0] stray_mask = '0;
    int            resp_delay = 0;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    assign unit_result       = {u_res[3], u_res[2], u_res[1], u_res[0]};
    assign unit_flags        = {u_flg[3], u_flg[2], u_flg[1], u_flg[0]};
    assign unit_result_valid = rv | stray_mask;

    w0rm_alu_sequencer #(
        .DATA_WIDTH(DW), .NUM_UNITS(NU), .TIMEOUT_CYCLES(TO), .DEST_WIDTH(DSTW)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_unit(in_unit), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .in_dest(in_dest), .unit_data_valid(unit_data_valid), .unit_opcode(unit_opcode),
        .unit_a(unit_a), .unit_b(unit_b), .unit_result(unit_result),
        .unit_result_valid(unit_result_valid), .unit_flags(unit_flags),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_dest(out_dest), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sub-unit model: answers resp_delay cycles after seeing its issue strobe (negative = never).
    int  r_cnt = 0;
    int  r_unit = 0;
    bit  r_pend = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            r_pend = 1'b0;
            rv     = '0;
        end else begin
            rv = '0;
            if (unit_data_valid != '0) begin
                r_pend = 1'b1;
                r_cnt  = 0;
                for (int k = 0; k < NU; k++) if (unit_data_valid[k]) r_unit = k;
            end else if (r_pend) begin
                r_cnt++;
            end
            if (r_pend && resp_delay >= 0 && r_cnt == resp_delay) begin
                rv[r_unit] = 1'b1;
                r_pend     = 1'b0;
            end
        end
    end

    // Transaction model: an accepted op issues next cycle and is ready after
    // min(response delay, TIMEOUT) + 1 further cycles; no response in time means zeros + error.
    int            cyc = 0;
    bit            m_active = 1'b0;
    bit            m_err = 1'b0;
    int            m_issue = 0;
    int            m_done = 0;
    int            m_unit = 0;
    logic [3:0]    m_op = '0;
    logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0, m_out_res = '0;
    logic [3:0]    m_flg = '0, m_out_flg = '0;
    logic [DSTW-1:0] m_dest = '0, m_out_dest = '0;

    always @(posedge clk) begin
        bit was;
        if (reset) begin
            m_active = 1'b0; m_op = '0; m_a = '0; m_b = '0;
            m_out_res = '0; m_out_flg = '0; m_out_dest = '0;
        end else begin
            was = m_active;
            if (m_active && cyc >= m_done && out_ready) m_active = 1'b0;
            if (!was && in_valid) begin
                m_active = 1'b1;
                m_unit   = int'(in_unit);
                m_op     = in_opcode;
                m_a      = in_a;
                m_b      = in_b;
                m_dest   = in_dest;
                m_err    = !(resp_delay >= 0 && resp_delay <= TO);
                m_issue  = cyc + 1;
                m_done   = m_issue + (m_err ? TO : resp_delay) + 1;
                m_res    = m_err ? '0 : u_res[m_unit];
                m_flg    = m_err ? '0 : u_flg[m_unit];
            end
        end
        cyc++;
        if (!reset && m_active && cyc == m_done) begin
            m_out_res  = m_res;
            m_out_flg  = m_flg;
            m_out_dest = m_dest;
        end
    end

    always @(negedge clk) begin
        logic [NU-1:0] e_udv;
        if (chk_en) begin
            if (reset) begin
                chk("rst_in_ready", in_ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_udv", unit_data_valid, 0);
                chk("rst_out_valid", out_valid, 0);
                chk("rst_timeout_err", timeout_err, 0);
                chk("rst_out_result", out_result, 0);
                chk("rst_out_flags", out_flags, 0);
                chk("rst_out_dest", out_dest, 0);
                chk("rst_unit_opcode", unit_opcode, 0);
                chk("rst_unit_a", unit_a, 0);
                chk("rst_unit_b", unit_b, 0);
            end else begin
                e_udv = (m_active && cyc == m_issue) ? (NU'(1) << m_unit) : '0;
                chk("m_in_ready", in_ready, !m_active);
                chk("m_busy", busy, m_active);
                chk("m_udv", unit_data_valid, e_udv);
                chk("m_out_valid", out_valid, m_active && cyc >= m_done);
                chk("m_timeout_err", timeout_err, m_active && cyc == m_done && m_err);
                chk("m_out_result", out_result, m_out_res);
                chk("m_out_flags", out_flags, m_out_flg);
                chk("m_out_dest", out_dest, m_out_dest);
                chk("m_unit_opcode", unit_opcode, m_op);
                chk("m_unit_a", unit_a, m_a);
                chk("m_unit_b", unit_b, m_b);
            end
        end
    end

    // Present an op and hold it until accepted; operands are then scrambled.
    task automatic issue_op(input logic [1:0] u, input logic [3:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DSTW-1:0] d);
        bit rdy;
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_unit = u; in_opcode = op; in_a = a; in_b = b; in_dest = d;
        do begin
            @(negedge clk); rdy = in_ready;
            @(posedge clk); n++;
        end while (!rdy && n < 50);
        if (!rdy) chk("accept_timeout", in_ready, 1);
        #1;
        in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF; in_opcode = 4'hF;
    endtask

    // Count negedges (ISSUE cycle = 0) until out_valid is seen.
    task automatic wait_ov(output int n);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 60) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) chk("out_valid_timeout", out_valid, 1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < NU; k++) begin
            u_res[k] = 8'hE0 + 8'(k);
            u_flg[k] = 4'(k + 8);
        end
        @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("lit_reset_in_ready", in_ready, 1);
        chk("lit_reset_out_valid", out_valid, 0);

        // Single-cycle logic unit
        resp_delay = 0; u_res[0] = 8'h30; u_flg[0] = 4'h0;
        issue_op(ALU_UNIT_LOGIC, ALU_OP_AND, 8'hF0, 8'h3C, 4'd5);
        @(negedge clk);
        chk("lit_and_udv", unit_data_valid, 4'b0001);
        chk("lit_and_unit_a", unit_a, 8'hF0);
        @(negedge clk);
        chk("lit_and_out_valid", out_valid, 1);
        chk("lit_and_result", out_result, 8'h30);
        chk("lit_and_dest", out_dest, 4'd5);

        // Multi-cycle multiplier, response 5 cycles after issue
        resp_delay = 5; u_res[3] = 8'h36; u_flg[3] = 4'h0;
        issue_op(ALU_UNIT_MUL, ALU_OP_MUL, 8'h12, 8'h03, 4'd9);
        wait_ov(n);
        chk("lit_mul_latency", n, 6);
        chk("lit_mul_result", out_result, 8'h36);

        // Timeout on a silent shift unit while a non-selected unit strobes
        resp_delay = -1; u_res[1] = 8'h77; u_flg[1] = 4'hF;
        issue_op(ALU_UNIT_SHIFT, ALU_OP_SHL, 8'h01, 8'h02, 4'd2);
        stray_mask = 4'b0001;
        wait_ov(n);
        stray_mask = '0;
        chk("lit_to_latency", n, 17);
        chk("lit_to_err", timeout_err, 1);
        chk("lit_to_result", out_result, 8'h00);
        chk("lit_to_flags", out_flags, 4'h0);
        @(negedge clk);
        chk("lit_to_err_pulse", timeout_err, 0);

        // Backpressure with a pending request and stray valids
        out_ready = 1'b0;
        resp_delay = 2; u_res[2] = 8'h5A; u_flg[2] = 4'hA;
        issue_op(ALU_UNIT_ARITH, ALU_OP_ADD, 8'h20, 8'h3A, 4'd3);
        wait_ov(n);
        chk("lit_bp_latency", n, 3);
        @(posedge clk); #1;
        in_valid = 1'b1; in_unit = ALU_UNIT_LOGIC; in_opcode = ALU_OP_XOR;
        in_a = 8'h0F; in_b = 8'h1E; in_dest = 4'd7;
        stray_mask = 4'b0100;
        resp_delay = 0; u_res[0] = 8'h11; u_flg[0] = 4'h1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lit_bp_hold_result", out_result, 8'h5A);
            chk("lit_bp_hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1; stray_mask = '0;
        @(negedge clk);
        chk("lit_bp_last_done", out_valid, 1);
        @(negedge clk);
        chk("lit_bp_idle_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_ov(n);
        chk("lit_bp_next_result", out_result, 8'h11);
        chk("lit_bp_next_dest", out_dest, 4'd7);

        // Asynchronous reset mid-WAIT, then a late completion
        resp_delay = -1;
        issue_op(ALU_UNIT_MUL, ALU_OP_MUL, 8'h44, 8'h55, 4'd1);
        repeat (4) @(negedge clk);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_unit_a", unit_a, 0);
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        stray_mask = 4'b1000;
        @(posedge clk); #1;
        stray_mask = '0;
        @(negedge clk);
        chk("lit_rst_late_valid", out_valid, 0);

        // Completion on the final timeout cycle wins
        resp_delay = TO; u_res[2] = 8'hC3; u_flg[2] = 4'h5;
        issue_op(ALU_UNIT_ARITH, ALU_OP_SUB, 8'h10, 8'h20, 4'd4);
        wait_ov(n);
        chk("lit_edge_latency", n, 17);
        chk("lit_edge_err", timeout_err, 0);
        chk("lit_edge_result", out_result, 8'hC3);
        chk("lit_edge_flags", out_flags, 4'h5);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1);
    end

endmodule

// File: doc/w0rm_alu_sequencer.md
Name: w0rm_alu_sequencer

Overview:
- Issue controller for the W0RM ALU sub-units: logic, shifts, add/sub and multiply.
- Accepts one decoded ALU operation per valid/ready handshake and pulses `data_valid` to the selected sub-unit.
- Waits for that sub-unit's `result_valid`, bounded by a timeout, then holds result, flags and destination register on a valid/ready writeback port.
- Sits between the decode stage and register-file writeback; handles single-cycle and multi-cycle sub-units uniformly.

Parameters:
- DATA_WIDTH, 8, operand/result width; matches the sub-units.
- NUM_UNITS, 4, number of ALU sub-units; fixed at 4, `unit_sel` is 2 bits.
- TIMEOUT_CYCLES, 16, max WAIT cycles before abort; legal range 1..255.
- DEST_WIDTH, 4, destination register index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  sequencer can accept a request.
- in_unit  in  2  sub-unit select (0 logic, 1 shifts, 2 add/sub, 3 mul).
- in_opcode  in  4  sub-unit opcode, passed through.
- in_a, in_b  in  DATA_WIDTH  operands.
- in_dest  in  DEST_WIDTH  destination register.
- unit_data_valid  out  NUM_UNITS  one-hot issue strobe.
- unit_opcode  out  4  latched opcode, broadcast to all units.
- unit_a, unit_b  out  DATA_WIDTH  latched operands, broadcast.
- unit_result  in  NUM_UNITS*DATA_WIDTH  concatenated results; unit k occupies slice [k*DATA_WIDTH +: DATA_WIDTH].
- unit_result_valid  in  NUM_UNITS  per-unit completion.
- unit_flags  in  NUM_UNITS*4  per-unit flags, slice [k*4 +: 4].
- out_valid  out  1  writeback data valid.
- out_ready  in  1  writeback consumer ready.
- out_result  out  DATA_WIDTH  captured result.
- out_flags  out  4  captured flags.
- out_dest  out  DEST_WIDTH  captured destination.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when an operation aborts.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. All state and outputs are registered except `in_ready` and `busy`, which decode state.
- Reset (async, any state, mid-operation included):
  - state goes to IDLE; `unit_data_valid`, `out_valid`, `timeout_err` go to 0.
  - `out_result`, `out_flags`, `out_dest`, the operand/opcode latches and the wait counter go to 0.
  - an in-flight sub-unit completion arriving after reset deasserts is ignored.
- IDLE: `in_ready`=1. On `in_valid && in_ready`, latch unit, opcode, a, b, dest; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `unit_data_valid[sel]`=1; all other bits 0; `unit_opcode`/`unit_a`/`unit_b` driven from the latches.
  - If `unit_result_valid[sel]` is also 1 this cycle (single-cycle unit): capture result and flags, go to DONE.
  - Otherwise clear the counter and go to WAIT.
- WAIT:
  - `unit_data_valid`=0; the counter increments each cycle.
  - If `unit_result_valid[sel]`: capture, go to DONE. Completion wins over timeout in the same cycle.
  - Else if counter == TIMEOUT_CYCLES-1: `out_result`=0, `out_flags`=0, `timeout_err` pulses 1 cycle, go to DONE.
- DONE:
  - `out_valid`=1, with result/flags/dest held stable until `out_valid && out_ready`; then go to IDLE.
  - `out_ready` may stay low indefinitely.
- `result_valid` from non-selected units, or from any unit in IDLE or DONE, is ignored.
- Operand latches hold through ISSUE and WAIT; `in_a`/`in_b` may change after acceptance without effect.
- Minimum latency: accept at cycle T, ISSUE at T+1, `out_valid` at T+2. Peak throughput is 1 op per 3 cycles with `out_ready` held high.

Decomposition:
- Shared package `w0rm_alu_pkg`:
  - unit select constants: ALU_UNIT_LOGIC=0, ALU_UNIT_SHIFT=1, ALU_UNIT_ARITH=2, ALU_UNIT_MUL=3.
  - ALU opcode localparams (AND=0, OR=1, XOR=2, NOT=3, NEG=4, ...).
  - flag bit positions.
  - sequencer state encoding.
- One natural sub-module, `w0rm_alu_result_mux`: combinational selection of result/flags/valid slices by unit index.

Test Plan:
- Single-cycle unit: in_unit=0, opcode=0 (AND), a=0xF0, b=0x3C; model unit 0 returns 0x30 with flags 0x0 in the issue cycle. Require `unit_data_valid`=0001 for exactly 1 cycle; `out_valid` at T+2 with result 0x30, dest preserved.
- Multi-cycle unit: in_unit=3 (mul), a=0x12, b=0x03; model returns 0x36 five cycles after issue. Require `busy` high throughout, `out_result`=0x36, `out_valid` exactly one cycle after `result_valid`.
- Timeout: in_unit=1, model never responds, TIMEOUT_CYCLES=16. Require `timeout_err` pulse 16 cycles after ISSUE, then `out_valid` with result 0x00 and flags 0x0.
- Backpressure and stray valids: `out_ready`=0 for 10 cycles in DONE; `in_valid` held high with new operands; unit 2 asserts `result_valid` spuriously. Require outputs stable, `in_ready`=0 and no new issue until the handshake; after it, the next op is accepted in IDLE.
- Reset mid-WAIT: assert reset asynchronously (between clock edges) during WAIT. Require immediate IDLE with all outputs 0; a late `result_valid` from the unit after reset release produces no `out_valid`.
- Completion and timeout in the same cycle: `result_valid` on the final timeout cycle. Require the normal result to be captured and `timeout_err` to stay 0.
